// File: rtl/vga_frame_ctrl.sv
// VGA raster timing with one-cycle-early pixel request, rgb gating and a
// frame-synchronous test-pattern scheduler (auto-advance or key pulse).
module vga_frame_ctrl #(
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int H_VALID        = 640,
    parameter int H_FRONT        = 16,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int V_VALID        = 480,
    parameter int V_FRONT        = 10,
    parameter int N_PATTERNS     = 4,
    parameter int PAT_W          = 2,
    parameter int FRAMES_PER_PAT = 60
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic [23:0]      pix_data,
    input  logic             auto_en,
    input  logic             next_pat,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic [23:0]      rgb,
    output logic             rgb_valid,
    output logic             frame_start,
    output logic [PAT_W-1:0] pat_sel
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FW      = $clog2(FRAMES_PER_PAT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SY   = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_END  = HW'(H_SYNC + H_BACK + H_VALID);
    localparam logic [HW-1:0] H_RQ   = HW'(H_SYNC + H_BACK - 1);
    localparam logic [HW-1:0] H_RQE  = HW'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_END  = VW'(V_SYNC + V_BACK + V_VALID);
    localparam logic [FW-1:0] FC_LAST  = FW'(FRAMES_PER_PAT - 1);
    localparam logic [PAT_W-1:0] P_LAST = PAT_W'(N_PATTERNS - 1);

    logic [HW-1:0]    cnt_h_q, cnt_h_d;
    logic [VW-1:0]    cnt_v_q, cnt_v_d;
    logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [PAT_W-1:0] pat_sel_q, pat_sel_d;
    logic             pend_q, pend_d;
    logic             frame_start_q, frame_start_d;
    logic             h_end, frame_end, auto_hit, pend_any;
    logic             h_act, v_act, h_req;

    always_comb begin
        h_end     = (cnt_h_q == H_LAST);
        frame_end = h_end && (cnt_v_q == V_LAST);
        cnt_h_d   = h_end ? '0 : cnt_h_q + HW'(1);
        cnt_v_d   = cnt_v_q;
        if (h_end)
            cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + VW'(1);

        // A key pulse landing on the frame-end cycle still counts for this boundary.
        auto_hit      = auto_en && (frame_cnt_q == FC_LAST);
        pend_any      = pend_q | next_pat;
        pend_d        = pend_any;
        frame_cnt_d   = frame_cnt_q;
        pat_sel_d     = pat_sel_q;
        frame_start_d = frame_end;
        if (frame_end) begin
            if (pend_any || auto_hit) begin
                pat_sel_d   = (pat_sel_q == P_LAST) ? '0 : pat_sel_q + PAT_W'(1);
                frame_cnt_d = '0;
                pend_d      = 1'b0;
            end else if (auto_en) begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            frame_cnt_q   <= '0;
            pat_sel_q     <= '0;
            pend_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            frame_cnt_q   <= frame_cnt_d;
            pat_sel_q     <= pat_sel_d;
            pend_q        <= pend_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Request window leads the visible window by one column to cover the
    // generator's registered latency.
    assign h_act = (cnt_h_q >= H_ACT) && (cnt_h_q < H_END);
    assign h_req = (cnt_h_q >= H_RQ) && (cnt_h_q < H_RQE);
    assign v_act = (cnt_v_q >= V_ACT) && (cnt_v_q < V_END);

    assign hsync       = (cnt_h_q < H_SY);
    assign vsync       = (cnt_v_q < V_SY);
    assign rgb_valid   = h_act && v_act;
    assign rgb         = rgb_valid ? pix_data : 24'h0;
    assign pix_x       = (h_req && v_act) ? 10'(cnt_h_q - H_RQ) : 10'h3FF;
    assign pix_y       = (h_req && v_act) ? 10'(cnt_v_q - V_ACT) : 10'h3FF;
    assign frame_start = frame_start_q;
    assign pat_sel     = pat_sel_q;

endmodule
